tone_key_gate: RTL

// - Downstream of the per-note square-wave generators: takes NUM_KEYS tone lines plus raw piano buttons.
// - Debounces the keys and selects one voice (last-pressed wins).
// - Gates the selected tone to the single speaker pin, optionally shaped by a PWM decay envelope.

---
 rtl/tone_key_gate_if.sv | 24 ++
 rtl/tone_key_gate.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tone_key_gate_if.sv
// Key/tone/speaker signal bundle for tone_key_gate.
// The master side drives buttons and tones, and the slave side is the gate.
interface tone_key_gate_if #(
    parameter int NUM_KEYS = 12
);
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] tone_in;
    logic [NUM_KEYS-1:0] key_valid;
    logic [KW-1:0]       active_key;
    logic                note_on;
    logic                audio_out;

    modport master (
        output key_n, tone_in,
        input  key_valid, active_key, note_on, audio_out
    );

    modport slave (
        input  key_n, tone_in,
        output key_valid, active_key, note_on, audio_out
    );
endinterface

// File: rtl/tone_key_gate.sv
// Debounced last-pressed-wins key selector gating one tone to the speaker.
// Define TONE_ENVELOPE_EN for the PWM decay envelope and the RELEASE state.
module tone_key_gate #(
    parameter int NUM_KEYS          = 12,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int PWM_BITS          = 8,
    parameter int DECAY_STEP_CYCLES = 195312,
    parameter int SUSTAIN           = 128
) (
    input logic            clk,
    input logic            reset,
    tone_key_gate_if.slave bus
);
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (SUSTAIN >= (2 ** PWM_BITS) || DECAY_STEP_CYCLES < 1
        || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("tone_key_gate: illegal parameter set");
    end

`ifdef TONE_ENVELOPE_EN
    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;
`else
    typedef enum logic {IDLE, PLAY} state_t;
`endif

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0] kv, kv_d;
    logic [NUM_KEYS-1:0] press, rel;
    logic [CW-1:0]       cnt [NUM_KEYS];
    state_t              state, state_nx;
    logic [KW-1:0]       act, act_nx;
    logic                gate;
    logic                audio;

    function automatic logic [KW-1:0] lowest(input logic [NUM_KEYS-1:0] v);
        lowest = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (v[i]) lowest = KW'(i);
    endfunction

    // Synchronizer stores the inverted level so reset means "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~bus.key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kv <= '0;
            for (int i = 0; i < NUM_KEYS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2[i] == kv[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    kv[i]  <= ~kv[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = kv & ~kv_d;
    assign rel   = ~kv & kv_d;

`ifdef TONE_ENVELOPE_EN
    localparam int SW = $clog2(DECAY_STEP_CYCLES + 1);

    logic [PWM_BITS-1:0] amp, pwm_cnt, floor_v;
    logic [SW-1:0]       step;

    assign floor_v = (state == PLAY) ? PWM_BITS'(SUSTAIN) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            amp     <= '0;
            step    <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (|press) begin
                amp  <= '1;
                step <= '0;
            end else if (state != IDLE && amp > floor_v) begin
                if (step == SW'(DECAY_STEP_CYCLES - 1)) begin
                    amp  <= amp - 1'b1;
                    step <= '0;
                end else begin
                    step <= step + 1'b1;
                end
            end else begin
                step <= '0;
            end
        end
    end

    assign gate = (state != IDLE) && (pwm_cnt < amp);
`else
    assign gate = (state == PLAY);
`endif

    always_comb begin
        act_nx   = act;
        state_nx = state;
        if (|press)
            act_nx = lowest(press);
        else if (rel[act] && |kv)
            act_nx = lowest(kv);
        unique case (state)
            IDLE: begin
                if (|press) state_nx = PLAY;
            end
            PLAY: begin
                if (!(|press) && !(|kv))
`ifdef TONE_ENVELOPE_EN
                    state_nx = RELEASE;
`else
                    state_nx = IDLE;
`endif
            end
`ifdef TONE_ENVELOPE_EN
            RELEASE: begin
                if (|press)
                    state_nx = PLAY;
                else if (amp == '0)
                    state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            act   <= '0;
            kv_d  <= '0;
            audio <= 1'b0;
        end else begin
            state <= state_nx;
            act   <= act_nx;
            kv_d  <= kv;
            audio <= bus.tone_in[act] & gate;
        end
    end

    assign bus.key_valid  = kv;
    assign bus.active_key = act;
    assign bus.note_on    = (state == PLAY);
    assign bus.audio_out  = audio;
endmodule
